// File: rtl/fetch_stage_if.sv
// fetch_stage_if: decode/hazard-side controls into the IF stage and the
// IF/ID register contents coming back out of it.
interface fetch_stage_if;
   logic        StallF;
   logic        StallD;
   logic        FlushD;
   logic        PCSrcD;
   logic        JumpD;
   logic [31:0] PCBranchD;
   logic [31:0] PCJumpD;
   logic [31:0] PCF;
   logic [31:0] instrD;
   logic [31:0] PCPlus4D;
   logic        ValidD;
   logic [31:0] FetchCount;

   // Decode / hazard unit side
   modport master (
      output StallF, StallD, FlushD, PCSrcD, JumpD, PCBranchD, PCJumpD,
      input  PCF, instrD, PCPlus4D, ValidD, FetchCount
   );

   // Fetch stage side
   modport slave (
      input  StallF, StallD, FlushD, PCSrcD, JumpD, PCBranchD, PCJumpD,
      output PCF, instrD, PCPlus4D, ValidD, FetchCount
   );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage of the 5-stage MIPS pipeline. Holds the PC, reads the
// instruction ROM combinationally and loads the IF/ID register for decode.
// The ROM image is a packed parameter: word i lives at bits [32*i+31:32*i].
module fetch_stage #(
   parameter logic [31:0]              RESET_PC   = 32'h0000_0000,
   parameter int                       IMEM_DEPTH = 256,
   parameter logic [32*IMEM_DEPTH-1:0] INIT_IMAGE = '0
) (
   input  logic         clkF,
   input  logic         rstF,
   fetch_stage_if.slave bus
);
   localparam int AW = $clog2(IMEM_DEPTH);

   typedef enum logic [1:0] {
      IFID_HOLD  = 2'd0,
      IFID_FLUSH = 2'd1,
      IFID_LOAD  = 2'd2
   } ifid_op_e;

   logic [31:0]   r_pc;
   logic [31:0]   r_instr;
   logic [31:0]   r_pc_plus4;
   logic          r_valid;
   logic [31:0]   r_fetch_count;

   logic [31:0]   w_pc_plus4;
   logic [31:0]   w_next_pc;
   logic [31:0]   w_rom_data;
   logic [AW-1:0] w_rom_index;
   logic          w_rom_hit;
   logic [31:0]   w_rom [IMEM_DEPTH];
   ifid_op_e      w_ifid_op;

   for (genvar g = 0; g < IMEM_DEPTH; g++) begin : g_rom
      assign w_rom[g] = INIT_IMAGE[32*g +: 32];
   end

   assign w_pc_plus4 = r_pc + 32'd4;
   assign w_rom_hit  = ((r_pc >> (AW + 2)) == 32'd0);

   // ROM read: addresses past the end of the image return 0 (sll $0 = nop)
   always_comb begin
      w_rom_index = r_pc[AW+1:2];
      if (w_rom_hit) begin
         w_rom_data = w_rom[w_rom_index];
      end else begin
         w_rom_data = 32'h0000_0000;
      end
   end

   // Next-PC select: jump beats branch beats sequential, word aligned
   always_comb begin
      w_next_pc = w_pc_plus4;
      if (bus.JumpD) begin
         w_next_pc = bus.PCJumpD;
      end else if (bus.PCSrcD) begin
         w_next_pc = bus.PCBranchD;
      end else begin
         w_next_pc = w_pc_plus4;
      end
      w_next_pc[1:0] = 2'b00;
   end

   // IF/ID action: a stall outranks a flush so a held instruction survives
   always_comb begin
      w_ifid_op = IFID_LOAD;
      if (bus.StallD) begin
         w_ifid_op = IFID_HOLD;
      end else if (bus.FlushD) begin
         w_ifid_op = IFID_FLUSH;
      end else begin
         w_ifid_op = IFID_LOAD;
      end
   end

   // PC register: redirects arriving during StallF are dropped
   always_ff @(posedge clkF or posedge rstF) begin
      if (rstF) begin
         r_pc <= RESET_PC;
      end else if (!bus.StallF) begin
         r_pc <= w_next_pc;
      end else begin
         r_pc <= r_pc;
      end
   end

   // IF/ID register and accepted-instruction counter
   always_ff @(posedge clkF or posedge rstF) begin
      if (rstF) begin
         r_instr       <= 32'h0000_0000;
         r_pc_plus4    <= 32'h0000_0000;
         r_valid       <= 1'b0;
         r_fetch_count <= 32'h0000_0000;
      end else begin
         case (w_ifid_op)
            IFID_FLUSH: begin
               r_instr    <= 32'h0000_0000;
               r_pc_plus4 <= 32'h0000_0000;
               r_valid    <= 1'b0;
            end
            IFID_LOAD: begin
               r_instr       <= w_rom_data;
               r_pc_plus4    <= w_pc_plus4;
               r_valid       <= 1'b1;
               r_fetch_count <= r_fetch_count + 32'd1;
            end
            default: begin
               r_instr       <= r_instr;
               r_pc_plus4    <= r_pc_plus4;
               r_valid       <= r_valid;
               r_fetch_count <= r_fetch_count;
            end
         endcase
      end
   end

   assign bus.PCF        = r_pc;
   assign bus.instrD     = r_instr;
   assign bus.PCPlus4D   = r_pc_plus4;
   assign bus.ValidD     = r_valid;
   assign bus.FetchCount = r_fetch_count;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus randomized control traffic. A
// reference model predicts the state after every clock edge; predictions go
// into a queue and a monitor compares them with the DUT after each edge.
module tb_fetch_stage;
   localparam int DEPTH = 256;

   function automatic logic [32*DEPTH-1:0] make_image();
      logic [32*DEPTH-1:0] img;
      img = '0;
      for (int i = 0; i < DEPTH; i++) img[32*i +: 32] = 32'h1000_0000 + 32'(i);
      return img;
   endfunction

   localparam logic [32*DEPTH-1:0] IMAGE = make_image();

   typedef struct {
      logic        sf, sd, fl, src, jmp;
      logic [31:0] pcb, pcj;
   } ctrl_t;

   typedef struct {
      logic [31:0] pc, instr, pp4, count;
      logic        valid;
   } exp_t;

   logic clkF;
   logic rstF;
   fetch_stage_if bus ();
   fetch_stage_if bus2 ();

   fetch_stage #(.RESET_PC(32'h0000_0000), .IMEM_DEPTH(DEPTH), .INIT_IMAGE(IMAGE))
      dut (.clkF(clkF), .rstF(rstF), .bus(bus));

   fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .IMEM_DEPTH(DEPTH), .INIT_IMAGE(IMAGE))
      dut_wrap (.clkF(clkF), .rstF(rstF), .bus(bus2));

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   // model state: what the IF stage should hold after the latest edge
   logic [31:0] m_pc, m_instr, m_pp4, m_count;
   logic        m_valid;

   initial clkF = 1'b0;
   always #5 clkF = ~clkF;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // ROM contents as the spec describes them: word n of the image, nop beyond
   function automatic logic [31:0] rom_ref(input logic [31:0] pc);
      if (pc < 32'(4 * DEPTH)) return 32'h1000_0000 + (pc / 32'd4);
      else return 32'h0000_0000;
   endfunction

   task automatic model_reset();
      m_pc = 32'h0000_0000; m_instr = 32'h0; m_pp4 = 32'h0; m_count = 32'h0; m_valid = 1'b0;
   endtask

   function automatic ctrl_t mk(input logic sf, sd, fl, src, jmp, input logic [31:0] pcb, pcj);
      ctrl_t c;
      c.sf = sf; c.sd = sd; c.fl = fl; c.src = src; c.jmp = jmp; c.pcb = pcb; c.pcj = pcj;
      return c;
   endfunction

   // Drive one cycle of controls at the falling edge and predict the next edge
   task automatic cycle(input ctrl_t c);
      exp_t        e;
      logic [31:0] tgt;
      @(negedge clkF);
      bus.StallF = c.sf; bus.StallD = c.sd; bus.FlushD = c.fl;
      bus.PCSrcD = c.src; bus.JumpD = c.jmp; bus.PCBranchD = c.pcb; bus.PCJumpD = c.pcj;
      if (!c.sd) begin
         if (c.fl) begin
            m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0;
         end else begin
            m_instr = rom_ref(m_pc); m_pp4 = m_pc + 32'd4; m_valid = 1'b1;
            m_count = m_count + 32'd1;
         end
      end
      if (!c.sf) begin
         if (c.jmp) tgt = c.pcj;
         else if (c.src) tgt = c.pcb;
         else tgt = m_pc + 32'd4;
         m_pc = tgt & 32'hFFFF_FFFC;
      end
      e.pc = m_pc; e.instr = m_instr; e.pp4 = m_pp4; e.count = m_count; e.valid = m_valid;
      sb.push_back(e);
   endtask

   task automatic idle();
      cycle(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0));
   endtask

   task automatic sync();
      @(posedge clkF);
      #2;
   endtask

   function automatic logic [31:0] pick_target();
      if ($urandom_range(0, 3) == 0) return $urandom;
      else return 32'($urandom_range(0, 4 * DEPTH + 64));
   endfunction

   // Monitor: one prediction consumed per edge taken out of reset
   initial begin
      exp_t e;
      forever begin
         @(posedge clkF);
         #1;
         if (rstF === 1'b0) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_underflow actual=empty expected=entry at %0t", $time);
            end else begin
               e = sb.pop_front();
               chk("mon_PCF", bus.PCF, e.pc);
               chk("mon_instrD", bus.instrD, e.instr);
               chk("mon_PCPlus4D", bus.PCPlus4D, e.pp4);
               chk("mon_ValidD", {31'd0, bus.ValidD}, {31'd0, e.valid});
               chk("mon_FetchCount", bus.FetchCount, e.count);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rstF = 1'b1;
      bus.StallF = 1'b0; bus.StallD = 1'b0; bus.FlushD = 1'b0; bus.PCSrcD = 1'b0;
      bus.JumpD = 1'b0; bus.PCBranchD = 32'h0; bus.PCJumpD = 32'h0;
      bus2.StallF = 1'b0; bus2.StallD = 1'b0; bus2.FlushD = 1'b0; bus2.PCSrcD = 1'b0;
      bus2.JumpD = 1'b0; bus2.PCBranchD = 32'h0; bus2.PCJumpD = 32'h0;
      model_reset();
      #3;
      chk("rst_PCF", bus.PCF, 32'h0);
      chk("rst_instrD", bus.instrD, 32'h0);
      chk("rst_PCPlus4D", bus.PCPlus4D, 32'h0);
      chk("rst_ValidD", {31'd0, bus.ValidD}, 32'h0);
      chk("rst_FetchCount", bus.FetchCount, 32'h0);
      chk("wrap_rst_PCF", bus2.PCF, 32'hFFFF_FFFC);
      sync();
      rstF = 1'b0;

      // 1: free-running fetch; the wrap instance crosses 0xFFFFFFFC -> 0
      idle();
      sync();
      chk("wrap_PCF", bus2.PCF, 32'h0);
      chk("wrap_PCPlus4D", bus2.PCPlus4D, 32'h0);
      chk("wrap_instrD", bus2.instrD, 32'h0);
      chk("wrap_ValidD", {31'd0, bus2.ValidD}, 32'h1);
      idle();
      sync();
      chk("wrap_second_instrD", bus2.instrD, 32'h1000_0000);
      idle();
      idle();
      sync();
      chk("t1_PCF", bus.PCF, 32'h10);
      chk("t1_instrD", bus.instrD, 32'h1000_0003);
      chk("t1_PCPlus4D", bus.PCPlus4D, 32'h10);
      chk("t1_FetchCount", bus.FetchCount, 32'd4);

      // 2: taken branch with flush from PCF=8
      cycle(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h8));
      cycle(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0));
      sync();
      chk("t2_PCF", bus.PCF, 32'h40);
      chk("t2_bubble_instrD", bus.instrD, 32'h0);
      chk("t2_bubble_ValidD", {31'd0, bus.ValidD}, 32'h0);
      chk("t2_bubble_count", bus.FetchCount, 32'd5);
      idle();
      sync();
      chk("t2_instrD", bus.instrD, 32'h1000_0010);
      chk("t2_PCPlus4D", bus.PCPlus4D, 32'h44);

      // 3: jump beats branch, low target bits masked
      cycle(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h40, 32'h80));
      sync();
      chk("t3_jump_wins", bus.PCF, 32'h80);
      cycle(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h83));
      sync();
      chk("t3_mask", bus.PCF, 32'h80);

      // 4: full stall with a flush in the middle, then release
      idle();
      cycle(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0));
      cycle(mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0));
      cycle(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h200));
      sync();
      chk("t4_hold_PCF", bus.PCF, 32'h84);
      chk("t4_hold_instrD", bus.instrD, 32'h1000_0020);
      idle();
      sync();
      chk("t4_resume_instrD", bus.instrD, 32'h1000_0021);

      // 5: fetch just past the end of the ROM returns a nop
      cycle(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'(4 * DEPTH)));
      idle();
      sync();
      chk("t5_oob_instrD", bus.instrD, 32'h0);
      chk("t5_oob_ValidD", {31'd0, bus.ValidD}, 32'h1);

      // 6: asynchronous reset between edges at PCF=0x20
      cycle(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h20));
      sync();
      chk("t6_pre_PCF", bus.PCF, 32'h20);
      #1;
      rstF = 1'b1;
      #1;
      chk("t6_async_PCF", bus.PCF, 32'h0);
      chk("t6_async_ValidD", {31'd0, bus.ValidD}, 32'h0);
      chk("t6_async_count", bus.FetchCount, 32'h0);
      model_reset();
      sync();
      rstF = 1'b0;
      idle();
      sync();
      chk("t6_first_instrD", bus.instrD, 32'h1000_0000);

      // Randomized hazard/redirect traffic
      for (int n = 0; n < 400; n++) begin
         ctrl_t c;
         c.sd  = ($urandom_range(0, 9) == 0);
         c.sf  = c.sd ? 1'b1 : ($urandom_range(0, 29) == 0);
         c.jmp = ($urandom_range(0, 9) == 0);
         c.src = ($urandom_range(0, 6) == 0);
         c.fl  = (c.jmp || c.src) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 19) == 0);
         c.pcb = pick_target();
         c.pcj = pick_target();
         cycle(c);
      end

      sync();
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
